fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
IF-stage program counter and IF/ID pipeline register. It consumes the ID-stage branch/jump decision (if_flush, pc_src, jump) and applies it. On a redirect it loads the branch or jump target into the PC and squashes the wrong-path instruction in IF/ID. It also honours the hazard-unit stall and counts flush events for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on flush (sll $0,$0,0)
CNT_W, 16, width of flush event counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard-unit stall: hold PC and IF/ID
if_flush  in  1  squash instruction currently in IF/ID
pc_src  in  1  taken conditional branch (beq) in ID
jump  in  1  j instruction in ID
branch_offset  in  32  sign-extended 16-bit immediate of the ID instruction (word offset)
jump_index  in  26  instr[25:0] of the ID instruction
instr_in  in  32  instruction memory read data at address pc
pc  out  32  instruction memory fetch address
ifid_pc4  out  32  PC+4 of the instruction held in IF/ID
ifid_instr  out  32  instruction held in IF/ID
ifid_valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble
flush_count  out  CNT_W  number of cycles in which a flush was applied (saturating)

Behaviour:
- Reset (async, any time including mid-redirect): pc=RESET_PC, ifid_pc4=0, ifid_instr=NOP_INSTR, ifid_valid=0, flush_count=0. First fetch occurs on the first rising edge after reset deasserts.
- Targets, computed combinationally from IF/ID contents:
  - branch_tgt = ifid_pc4 + (branch_offset << 2), 32-bit wrap-around add, no overflow detection.
  - jump_tgt = {ifid_pc4[31:28], jump_index, 2'b00}.
- Priority per rising edge, highest first:
  1. stall=1: pc, ifid_* and flush_count hold. if_flush, pc_src and jump are ignored this cycle. The ID instruction is re-evaluated on the next unstalled cycle.
  2. jump=1: pc<=jump_tgt; IF/ID <= {pc+4, NOP_INSTR, valid=0}; flush_count++.
  3. pc_src=1: pc<=branch_tgt; IF/ID flushed as in 2; flush_count++.
  4. if_flush=1 with no pc_src or jump: pc<=pc+4; IF/ID flushed; flush_count++.
  5. Otherwise: pc<=pc+4; ifid_pc4<=pc+4; ifid_instr<=instr_in; ifid_valid<=1.
- jump and pc_src both high: jump wins.
- A redirect always flushes, whether or not if_flush is asserted.
- Redirect penalty is exactly one bubble. The target instruction is fetched in the cycle after the redirect edge and enters IF/ID on the following edge.
- Redirect inputs are qualified by ifid_valid: if ifid_valid=0, jump and pc_src are ignored, so a bubble cannot redirect. if_flush still applies.
- PC is not forced to word alignment. pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- flush_count saturates at all-ones and never wraps.
- Outputs are registered only. There are no combinational paths from inputs to pc or ifid_*.

Test Plan:
- Reset then 4 free-running cycles with instr_in=A,B,C,D -> pc 0,4,8,12,16; IF/ID shows (4,A),(8,B),(12,C),(16,D), ifid_valid=1.
- Branch: IF/ID holds pc4=0x10, branch_offset=32'hFFFF_FFFC, pc_src=1, if_flush=1 -> next pc=0x0000_0000, ifid_instr=NOP, ifid_valid=0, flush_count=1. Following edge loads the instruction at address 0.
- Jump: ifid_pc4=0x4000_0008, jump_index=26'h000_0040, jump=1, pc_src=1 -> pc=0x4000_0100 (jump priority), one bubble, flush_count=1.
- Stall vs redirect: stall=1 with jump=1 for 2 cycles -> pc/IF/ID/flush_count unchanged. Stall drops -> jump applied on that edge.
- Bubble qualification: ifid_valid=0, pc_src=1 -> pc advances +4, no redirect. Separately, if_flush alone -> pc+4, IF/ID = NOP, count++.
- Reset mid-operation: assert reset asynchronously in the cycle after a redirect -> all outputs return to reset values immediately, before the next clock edge. Separately, with CNT_W=2, 5 flushes -> flush_count holds 3.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// IF-stage program counter and IF/ID pipeline register.
// Applies the ID-stage branch/jump decision: a redirect loads the target into
// the PC and squashes the wrong-path instruction sitting in IF/ID. A hazard
// stall freezes everything. Flush events are counted in a saturating counter.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             if_flush,
  input  logic             pc_src,
  input  logic             jump,
  input  logic [31:0]      branch_offset,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      instr_in,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_pc4,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP
  } pc_sel_e;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;
  logic        do_flush;
  pc_sel_e     pc_sel;

  assign pc_plus4   = pc + 32'd4;
  assign branch_tgt = ifid_pc4 + (branch_offset << 2);
  assign jump_tgt   = {ifid_pc4[31:28], jump_index, 2'b00};

  // Decode the redirect: only a real instruction in IF/ID may redirect, jump beats branch.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    pc_sel   = SEL_SEQ;
    do_flush = if_flush;
    if (ifid_valid && jump) begin
      pc_sel   = SEL_JUMP;
      do_flush = 1'b1;
    end else if (ifid_valid && pc_src) begin
      pc_sel   = SEL_BRANCH;
      do_flush = 1'b1;
    end
  end

  // Select the next fetch address.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      SEL_JUMP:   next_pc = jump_tgt;
      SEL_BRANCH: next_pc = branch_tgt;
      default:    next_pc = pc_plus4;
    endcase
  end

  // PC and IF/ID register; a stall holds both, a flush inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      pc         <= RESET_PC;
      ifid_pc4   <= 32'h0000_0000;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= next_pc;
      ifid_pc4 <= pc_plus4;
      if (do_flush) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr <= instr_in;
        ifid_valid <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which a flush was applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count <= '0;
    end else if (!stall && do_flush && (flush_count != '1)) begin
      flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed scenarios with literal
// expectations, then randomized control traffic compared every cycle against
// a behavioural model. A second instance with a 2-bit counter covers saturation.
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, if_flush, pc_src, jump;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] instr_in;
  logic [31:0] pc, ifid_pc4, ifid_instr;
  logic        ifid_valid;
  logic [15:0] flush_count;
  logic [31:0] pc_s, ifid_pc4_s, ifid_instr_s;
  logic        ifid_valid_s;
  logic [1:0]  flush_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_flushes;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign instr_in = imem(pc);

  fetch_redirect_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .if_flush(if_flush),
    .pc_src(pc_src), .jump(jump), .branch_offset(branch_offset),
    .jump_index(jump_index), .instr_in(instr_in), .pc(pc),
    .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .flush_count(flush_count)
  );

  fetch_redirect_unit #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .if_flush(if_flush),
    .pc_src(pc_src), .jump(jump), .branch_offset(branch_offset),
    .jump_index(jump_index), .instr_in(instr_in), .pc(pc_s),
    .ifid_pc4(ifid_pc4_s), .ifid_instr(ifid_instr_s), .ifid_valid(ifid_valid_s),
    .flush_count(flush_count_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain statement of the fetch rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc      <= 32'h0;
      m_pc4     <= 32'h0;
      m_instr   <= NOP;
      m_valid   <= 1'b0;
      m_flushes <= 0;
    end else if (!stall) begin
      if (m_valid && jump)
        m_pc <= (m_pc4 & 32'hF000_0000) | (32'(jump_index) * 4);
      else if (m_valid && pc_src)
        m_pc <= m_pc4 + branch_offset * 4;
      else
        m_pc <= m_pc + 4;
      m_pc4 <= m_pc + 4;
      if (if_flush || (m_valid && (jump || pc_src))) begin
        m_instr   <= NOP;
        m_valid   <= 1'b0;
        m_flushes <= m_flushes + 1;
      end else begin
        m_instr <= imem(m_pc);
        m_valid <= 1'b1;
      end
    end
  end

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("pc", pc, m_pc);
      check("ifid_pc4", ifid_pc4, m_pc4);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      check("flush_count", 32'(flush_count), (m_flushes > 65535) ? 32'hFFFF : 32'(m_flushes));
      check("flush_count_sat", 32'(flush_count_s), (m_flushes > 3) ? 32'd3 : 32'(m_flushes));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic j,
                       input logic [31:0] off, input logic [25:0] idx);
    stall = s; if_flush = f; pc_src = b; jump = j;
    branch_offset = off; jump_index = idx;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                              input logic [31:0] e_instr, input logic e_valid, input int e_cnt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".ifid_pc4"}, ifid_pc4, e_pc4);
    check({tag, ".ifid_instr"}, ifid_instr, e_instr);
    check({tag, ".ifid_valid"}, 32'(ifid_valid), 32'(e_valid));
    check({tag, ".flush_count"}, 32'(flush_count), 32'(e_cnt));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 26'h0);
    #3;
    expect_state("reset", 32'h0, 32'h0, NOP, 1'b0, 0);
    tick();
    #1 reset = 1'b0;
    check("first_pc", pc, 32'h0);

    // free-running fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_state("seq", 32'(4 * i), 32'(4 * i), imem(32'(4 * (i - 1))), 1'b1, 0);
    end

    // taken branch back to 0 with if_flush
    drive(0, 1, 1, 0, 32'hFFFF_FFFC, 26'h0);
    tick();
    expect_state("branch", 32'h0, 32'h14, NOP, 1'b0, 1);
    drive(0, 0, 0, 0, 32'h0, 26'h0);
    tick();
    expect_state("branch_fill", 32'h4, 32'h4, imem(32'h0), 1'b1, 1);

    // branch to the top word, then pc+4 wraps to 0
    drive(0, 0, 1, 0, 32'hFFFF_FFFE, 26'h0);
    tick();
    expect_state("to_top", 32'hFFFF_FFFC, 32'h8, NOP, 1'b0, 2);
    drive(0, 0, 0, 0, 32'h0, 26'h0);
    tick();
    expect_state("wrap", 32'h0, 32'h0, imem(32'hFFFF_FFFC), 1'b1, 2);

    // reach ifid_pc4 = 0x4000_0008 for the jump case
    drive(0, 0, 1, 0, 32'h1000_0001, 26'h0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 26'h0);
    tick();
    expect_state("pre_jump", 32'h4000_0008, 32'h4000_0008, imem(32'h4000_0004), 1'b1, 3);

    // jump and branch together: jump wins
    drive(0, 0, 1, 1, 32'h10, 26'h000_0040);
    tick();
    expect_state("jump", 32'h4000_0100, 32'h4000_000C, NOP, 1'b0, 4);
    drive(0, 0, 0, 0, 32'h0, 26'h0);
    tick();
    expect_state("jump_fill", 32'h4000_0104, 32'h4000_0104, imem(32'h4000_0100), 1'b1, 4);

    // stall masks a pending jump for two cycles
    drive(1, 0, 0, 1, 32'h0, 26'h000_0080);
    tick();
    expect_state("stall1", 32'h4000_0104, 32'h4000_0104, imem(32'h4000_0100), 1'b1, 4);
    tick();
    expect_state("stall2", 32'h4000_0104, 32'h4000_0104, imem(32'h4000_0100), 1'b1, 4);
    stall = 1'b0;
    tick();
    expect_state("unstall_jump", 32'h4000_0200, 32'h4000_0108, NOP, 1'b0, 5);

    // a bubble cannot redirect
    drive(0, 0, 1, 0, 32'h100, 26'h0);
    tick();
    expect_state("bubble_no_redirect", 32'h4000_0204, 32'h4000_0204, imem(32'h4000_0200), 1'b1, 5);

    // if_flush alone
    drive(0, 1, 0, 0, 32'h0, 26'h0);
    tick();
    expect_state("flush_only", 32'h4000_0208, 32'h4000_0208, NOP, 1'b0, 6);
    check("sat_count", 32'(flush_count_s), 32'd3);

    // asynchronous reset in the cycle after a redirect
    drive(0, 0, 0, 0, 32'h0, 26'h0);
    tick();
    drive(0, 0, 0, 1, 32'h0, 26'h0);
    tick();
    check("pre_reset_pc", pc, 32'h4000_0000);
    #1 reset = 1'b1;
    #1;
    expect_state("async_reset", 32'h0, 32'h0, NOP, 1'b0, 0);
    check("async_reset_sat", 32'(flush_count_s), 32'd0);
    drive(0, 0, 0, 0, 32'h0, 26'h0);
    tick();
    #1 reset = 1'b0;

    // randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      r = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      jump     = ($urandom_range(0, 6) == 0);
      pc_src   = ($urandom_range(0, 4) == 0);
      if_flush = ($urandom_range(0, 4) == 0);
      branch_offset = r[31] ? {{16{r[15]}}, r[15:0]} : $urandom;
      jump_index    = 26'($urandom);
      tick();
      if (reset) begin
        #1 reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
      end
    end

    drive(0, 0, 0, 0, 32'h0, 26'h0);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
